// File: rtl/lif_neuron_layer.sv
// Leaky integrate-and-fire output layer: one timestep per step_valid strobe, with
// saturating per-neuron spike counters and a sequential winner-take-all readout.
module lif_neuron_layer #(
  parameter int NUM_NEURONS   = 10,
  parameter int CURRENT_WIDTH = 16,
  parameter int V_WIDTH       = 16,
  parameter int V_THRESH      = 4000,
  parameter int V_REST        = 0,
  parameter int LEAK_SHIFT    = 4,
  parameter int REFRACT_STEPS = 5,
  parameter int COUNT_WIDTH   = 8,
  parameter int IDX_WIDTH     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 step_valid,
  input  logic [NUM_NEURONS*CURRENT_WIDTH-1:0] currents_in,
  output logic [NUM_NEURONS-1:0]               post_spikes,
  output logic                                 spikes_valid,
  input  logic                                 clear_counts,
  output logic [NUM_NEURONS*COUNT_WIDTH-1:0]   spike_counts,
  input  logic                                 winner_req,
  output logic                                 winner_busy,
  output logic                                 winner_valid,
  output logic [IDX_WIDTH-1:0]                 winner_idx,
  output logic [COUNT_WIDTH-1:0]               winner_count
);

  localparam int R_W = (REFRACT_STEPS < 1) ? 1 : $clog2(REFRACT_STEPS + 1);
  localparam logic [V_WIDTH-1:0]     V_MAX    = '1;
  localparam logic [V_WIDTH-1:0]     V_THR    = V_WIDTH'(V_THRESH);
  localparam logic [V_WIDTH-1:0]     V_RST    = V_WIDTH'(V_REST);
  localparam logic [R_W-1:0]         R_LOAD   = R_W'(REFRACT_STEPS);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [IDX_WIDTH-1:0]   LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  function automatic logic [V_WIDTH-1:0] sat_v(input logic [V_WIDTH:0] x);
    return x[V_WIDTH] ? V_MAX : x[V_WIDTH-1:0];
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + COUNT_WIDTH'(1);
  endfunction

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  logic [V_WIDTH-1:0]     v_q    [NUM_NEURONS];
  logic [R_W-1:0]         refr_q [NUM_NEURONS];
  logic [COUNT_WIDTH-1:0] cnt_q  [NUM_NEURONS];
  logic [V_WIDTH:0]       v_sum  [NUM_NEURONS];
  logic [V_WIDTH-1:0]     v_next [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] fire;
  logic [NUM_NEURONS-1:0] spikes_p1;
  logic                   vld_p1;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   scan_idx;
  logic [COUNT_WIDTH-1:0] best, scan_cnt;
  logic [IDX_WIDTH-1:0]   best_idx;
  logic                   beats;

  // Leak is subtracted before adding current; the extra top bit catches overflow.
  always_comb begin
    fire = '0;
    for (int k = 0; k < NUM_NEURONS; k++) begin
      v_sum[k]  = {1'b0, v_q[k]} - {1'b0, v_q[k] >> LEAK_SHIFT}
                + (V_WIDTH+1)'(currents_in[k*CURRENT_WIDTH +: CURRENT_WIDTH]);
      v_next[k] = sat_v(v_sum[k]);
      fire[k]   = (refr_q[k] == '0) && (v_next[k] >= V_THR);
    end
  end

  // Stage p0 -> p1: membrane state, spike register and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_q[k]    <= V_RST;
        refr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      spikes_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1    <= step_valid;
      spikes_p1 <= step_valid ? fire : '0;
      for (int k = 0; k < NUM_NEURONS; k++) begin
        if (step_valid) begin
          if (refr_q[k] != '0) begin
            refr_q[k] <= refr_q[k] - R_W'(1);
            v_q[k]    <= V_RST;
          end else if (fire[k]) begin
            refr_q[k] <= R_LOAD;
            v_q[k]    <= V_RST;
          end else begin
            v_q[k]    <= v_next[k];
          end
        end
        if (clear_counts)
          cnt_q[k] <= '0;
        else if (step_valid && fire[k])
          cnt_q[k] <= sat_inc(cnt_q[k]);
      end
    end
  end

  assign post_spikes  = spikes_p1;
  assign spikes_valid = vld_p1;

  always_comb begin
    spike_counts = '0;
    for (int k = 0; k < NUM_NEURONS; k++)
      spike_counts[k*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (winner_req) state_d = SCAN;
      SCAN:    if (scan_idx == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    winner_busy  = (state_q == SCAN);
    winner_valid = (state_q == DONE);
  end

  // Scan reads the live counter, so spikes landing mid-scan are still seen.
  assign scan_cnt = cnt_q[scan_idx];
  assign beats    = scan_cnt > best;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx     <= '0;
      best         <= '0;
      best_idx     <= '0;
      winner_idx   <= '0;
      winner_count <= '0;
    end else begin
      case (state_q)
        IDLE: if (winner_req) begin
          scan_idx <= '0;
          best     <= '0;
          best_idx <= '0;
        end
        SCAN: begin
          if (beats) begin
            best     <= scan_cnt;
            best_idx <= scan_idx;
          end
          scan_idx <= scan_idx + IDX_WIDTH'(1);
          if (scan_idx == LAST_IDX) begin
            winner_idx   <= beats ? scan_idx : best_idx;
            winner_count <= beats ? scan_cnt : best;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_layer.sv
// Self-checking bench for lif_neuron_layer: per-cycle comparison against a behavioural
// model, plus directed literal expectations for integration, refractory, saturation and WTA.
module tb_lif_neuron_layer;
  localparam int N  = 10;
  localparam int CW = 16;
  localparam int KW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1, step_valid = 1'b0, clear_counts = 1'b0, winner_req = 1'b0;
  logic [N*CW-1:0] currents = '0;
  logic [N-1:0]    post_spikes;
  logic            spikes_valid, winner_busy, winner_valid;
  logic [N*KW-1:0] spike_counts;
  logic [3:0]      winner_idx;
  logic [KW-1:0]   winner_count;

  logic            sat_step = 1'b0;
  logic [N*CW-1:0] sat_cur = '0;
  logic [N-1:0]    sat_spk;
  logic            sat_vld, sat_busy, sat_wvld;
  logic [N*2-1:0]  sat_counts;
  logic [3:0]      sat_widx;
  logic [1:0]      sat_wcnt;

  lif_neuron_layer dut (
    .clk(clk), .rst(rst), .step_valid(step_valid), .currents_in(currents),
    .post_spikes(post_spikes), .spikes_valid(spikes_valid), .clear_counts(clear_counts),
    .spike_counts(spike_counts), .winner_req(winner_req), .winner_busy(winner_busy),
    .winner_valid(winner_valid), .winner_idx(winner_idx), .winner_count(winner_count)
  );

  lif_neuron_layer #(.V_THRESH(65535), .COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .step_valid(sat_step), .currents_in(sat_cur),
    .post_spikes(sat_spk), .spikes_valid(sat_vld), .clear_counts(1'b0),
    .spike_counts(sat_counts), .winner_req(1'b0), .winner_busy(sat_busy),
    .winner_valid(sat_wvld), .winner_idx(sat_widx), .winner_count(sat_wcnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the default-parameter instance
  int          m_v[N], m_ref[N], m_cnt[N], seen[N];
  logic [N-1:0] e_spk;
  logic        e_vld, e_busy, e_wvld;
  int          e_widx, e_wcnt, mode, pos;
  bit          armed = 0;

  initial begin
    int nv;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int k = 0; k < N; k++) begin m_v[k] = 0; m_ref[k] = 0; m_cnt[k] = 0; end
        e_spk = '0; e_vld = 0; e_widx = 0; e_wcnt = 0; mode = 0; pos = 0;
        armed = 1;
      end else begin
        if (mode == 2) mode = 0;
        else if (mode == 1) begin
          seen[pos] = m_cnt[pos];
          pos++;
          if (pos == N) begin
            e_widx = 0; e_wcnt = seen[0];
            for (int i = 1; i < N; i++)
              if (seen[i] > e_wcnt) begin e_wcnt = seen[i]; e_widx = i; end
            mode = 2;
          end
        end else if (winner_req) begin
          mode = 1; pos = 0;
        end
        e_vld = step_valid;
        e_spk = '0;
        if (step_valid) begin
          for (int k = 0; k < N; k++) begin
            if (m_ref[k] > 0) begin
              m_ref[k]--; m_v[k] = 0;
            end else begin
              nv = m_v[k] - m_v[k] / 16 + int'(currents[k*CW +: CW]);
              if (nv > 65535) nv = 65535;
              if (nv >= 4000) begin e_spk[k] = 1'b1; m_v[k] = 0; m_ref[k] = 5; end
              else m_v[k] = nv;
            end
          end
        end
        for (int k = 0; k < N; k++) begin
          if (clear_counts) m_cnt[k] = 0;
          else if (e_spk[k] && m_cnt[k] < 255) m_cnt[k]++;
        end
      end
      e_busy = (mode == 1);
      e_wvld = (mode == 2);
    end
  end

  initial begin
    logic [N*KW-1:0] pk;
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int k = 0; k < N; k++) pk[k*KW +: KW] = 8'(m_cnt[k]);
        check("post_spikes", post_spikes, e_spk);
        check("spikes_valid", spikes_valid, e_vld);
        check("spike_counts", spike_counts, pk);
        check("winner_busy", winner_busy, e_busy);
        check("winner_valid", winner_valid, e_wvld);
        check("winner_idx", winner_idx, 4'(e_widx));
        check("winner_count", winner_count, 8'(e_wcnt));
      end
    end
  end

  initial begin
    int vseen;
    tick(); tick();
    rst = 1'b0;
    check("rst_spikes", post_spikes, 0);
    check("rst_valid", spikes_valid, 0);
    check("rst_counts", spike_counts, 0);
    check("rst_busy", winner_busy, 0);
    check("rst_wvalid", winner_valid, 0);
    check("rst_widx", winner_idx, 0);
    check("rst_wcount", winner_count, 0);

    step_valid = 1'b1; tick(); step_valid = 1'b0;
    check("first_step_valid", spikes_valid, 1);
    check("first_step_spikes", post_spikes, 0);
    tick();
    check("valid_single_cycle", spikes_valid, 0);

    // Neuron 0 driven with 1000 for 15 back-to-back steps
    currents = '0; currents[0 +: CW] = 16'd1000; step_valid = 1'b1;
    for (int s = 1; s <= 15; s++) begin
      tick();
      if (s == 1) check("model_v_step1", m_v[0], 1000);
      if (s == 2) check("model_v_step2", m_v[0], 1938);
      if (s == 3) check("model_v_step3", m_v[0], 2817);
      if (s == 4) check("model_v_step4", m_v[0], 3641);
      if (s == 5) begin
        check("spike_step5", post_spikes, 10'b1);
        check("v_after_spike", m_v[0], 0);
      end
      if (s >= 6 && s <= 14) check("no_spike_refract_reint", post_spikes[0], 0);
      if (s == 15) check("spike_step15", post_spikes[0], 1);
    end
    step_valid = 1'b0; currents = '0;
    tick();
    check("count0_two", spike_counts[0 +: KW], 2);
    check("spikes_idle_zero", post_spikes, 0);

    // clear_counts coinciding with a spike on neuron 5
    currents[5*CW +: CW] = 16'd5000; step_valid = 1'b1; clear_counts = 1'b1;
    tick();
    step_valid = 1'b0; clear_counts = 1'b0; currents = '0;
    check("clear_spike_visible", post_spikes[5], 1);
    check("clear_count5", spike_counts[5*KW +: KW], 0);
    check("clear_count0", spike_counts[0 +: KW], 0);
    tick();

    // Saturation instance: threshold at full scale, 2-bit counters
    sat_cur[0 +: CW] = 16'hFFFF; sat_cur[CW +: CW] = 16'd100; sat_step = 1'b1;
    tick();
    check("sat_exact_thresh", sat_spk, 10'b01);
    check("sat_count_first", sat_counts[1:0], 1);
    sat_cur[CW +: CW] = 16'hFFFF;
    tick();
    check("sat_clamp_fire", sat_spk, 10'b10);
    for (int s = 3; s <= 25; s++) tick();
    sat_step = 1'b0;
    tick();
    check("sat_count0_cap", sat_counts[1:0], 3);
    check("sat_count1_cap", sat_counts[3:2], 3);

    // Build counts {3,7,7,1,0...} for the winner scan
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    step_valid = 1'b1;
    for (int s = 1; s <= 42; s++) begin
      currents = '0;
      if (s <= 18) currents[0 +: CW] = 16'd4000;
      currents[CW +: CW]   = 16'd4000;
      currents[2*CW +: CW] = 16'd4000;
      if (s <= 6) currents[3*CW +: CW] = 16'd4000;
      tick();
    end
    step_valid = 1'b0; currents = '0;
    tick();
    check("wta_counts", spike_counts[31:0], 32'h01070703);

    winner_req = 1'b1; tick(); winner_req = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check("wta_busy_window", winner_busy, (c <= 10));
      check("wta_valid_time", winner_valid, (c == 11));
      if (c == 11) begin
        check("wta_idx", winner_idx, 1);
        check("wta_count", winner_count, 7);
      end
      winner_req = (c == 3);
      tick();
    end
    winner_req = 1'b0;
    check("wta_hold_idx", winner_idx, 1);

    // Reset in the middle of a scan must suppress winner_valid
    winner_req = 1'b1; tick(); winner_req = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    vseen = 0;
    for (int c = 0; c < 14; c++) begin
      if (winner_valid) vseen++;
      tick();
    end
    check("abort_no_valid", vseen, 0);
    check("abort_idx_cleared", winner_idx, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
